// File: rtl/mbus_ice_driver_rx.sv
// ---------------------------------------------------------------------------
// mbus_ice_driver_rx
//
// Purpose:
//   Receive half of the ICE MBUS driver. Inbound MBUS messages (an address
//   followed by one or more 32-bit data words) arrive over the MBUS rx
//   4-phase handshake. Each message is serialized MSB-first into one
//   byte-wide frame toward the ICE bus interface:
//     header {7'b0,broadcast}, addr[4 bytes], data[4 bytes per word],
//     status {6'b0,overflow,fail}.
//   The next MBUS word is not acknowledged until the previous word has been
//   fully drained to the byte interface. Words beyond MAX_WORDS are acked and
//   dropped, and the overflow bit is reported in the status byte.
//
// Ports:
//   clk, reset            clock and synchronous active-high reset
//   rx_mbus_rxaddr  [31:0] MBUS address, valid with the first rxreq
//   rx_mbus_rxdata  [31:0] MBUS data word, valid while rxreq=1
//   rx_mbus_rxreq          MBUS word request (4-phase)
//   rx_mbus_rxpend         more words follow this one
//   rx_mbus_rxbroadcast    message is broadcast (first word only)
//   rx_mbus_rxfail         message aborted by the MBUS layer
//   rx_mbus_rxack          MBUS word acknowledge (4-phase)
//   rx_frame_valid         high from header byte through status acceptance
//   rx_char          [7:0] current frame byte
//   rx_char_valid          rx_char valid, held stable until accepted
//   rx_char_ready          byte consumer ready
//   rx_char_last           marks the status byte
// ---------------------------------------------------------------------------
module mbus_ice_driver_rx #(
  parameter int MAX_WORDS = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] rx_mbus_rxaddr,
  input  logic [31:0] rx_mbus_rxdata,
  input  logic        rx_mbus_rxreq,
  input  logic        rx_mbus_rxpend,
  input  logic        rx_mbus_rxbroadcast,
  input  logic        rx_mbus_rxfail,
  output logic        rx_mbus_rxack,
  output logic        rx_frame_valid,
  output logic [7:0]  rx_char,
  output logic        rx_char_valid,
  input  logic        rx_char_ready,
  output logic        rx_char_last
);

  localparam int WCW = $clog2(MAX_WORDS + 1);
  localparam logic [WCW-1:0] MAXW_C = WCW'(MAX_WORDS);

  typedef enum logic [3:0] {
    IDLE,
    ACK0,
    HDR,
    ADDR,
    DATA,
    WAITW,
    ACKD,
    ACKX,
    STATUS
  } state_t;

  state_t         state_q;
  logic [31:0]    addr_q;
  logic [31:0]    data_q;
  logic [1:0]     bcnt_q;
  logic [WCW-1:0] wcnt_q;
  logic           fail_q;
  logic           ovf_q;
  logic           bcast_q;
  logic           pend_q;

  logic           accept;

  assign accept = rx_char_valid & rx_char_ready;

  // Message sequencer. Address and data are shifted left as bytes leave so
  // the outgoing byte is always the top byte of the register. A failure seen
  // mid-message is made sticky; the word in flight still drains fully
  // before the status byte closes the frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      bcnt_q  <= '0;
      wcnt_q  <= '0;
      fail_q  <= 1'b0;
      ovf_q   <= 1'b0;
      bcast_q <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      if (rx_mbus_rxfail && state_q != IDLE && state_q != STATUS) begin
        fail_q <= 1'b1;
      end

      case (state_q)
        IDLE: begin
          if (rx_mbus_rxreq) begin
            addr_q  <= rx_mbus_rxaddr;
            data_q  <= rx_mbus_rxdata;
            pend_q  <= rx_mbus_rxpend;
            bcast_q <= rx_mbus_rxbroadcast;
            fail_q  <= 1'b0;
            ovf_q   <= 1'b0;
            wcnt_q  <= WCW'(1);
            bcnt_q  <= '0;
            state_q <= ACK0;
          end
        end

        ACK0: begin
          if (!rx_mbus_rxreq) begin
            state_q <= HDR;
          end
        end

        HDR: begin
          if (accept) begin
            bcnt_q  <= '0;
            state_q <= ADDR;
          end
        end

        ADDR: begin
          if (accept) begin
            addr_q <= {addr_q[23:0], 8'h00};
            if (bcnt_q == 2'd3) begin
              bcnt_q  <= '0;
              state_q <= DATA;
            end else begin
              bcnt_q <= bcnt_q + 2'd1;
            end
          end
        end

        DATA: begin
          if (accept) begin
            data_q <= {data_q[23:0], 8'h00};
            if (bcnt_q == 2'd3) begin
              bcnt_q  <= '0;
              state_q <= (pend_q && !fail_q) ? WAITW : STATUS;
            end else begin
              bcnt_q <= bcnt_q + 2'd1;
            end
          end
        end

        // A failure (fresh or one that landed on the last data byte) wins
        // over a simultaneous word request, so no word is acked after it.
        WAITW: begin
          if (rx_mbus_rxfail || fail_q) begin
            fail_q  <= 1'b1;
            state_q <= STATUS;
          end else if (rx_mbus_rxreq) begin
            pend_q <= rx_mbus_rxpend;
            if (wcnt_q < MAXW_C) begin
              data_q  <= rx_mbus_rxdata;
              wcnt_q  <= wcnt_q + WCW'(1);
              state_q <= ACKD;
            end else begin
              ovf_q   <= 1'b1;
              state_q <= ACKX;
            end
          end
        end

        ACKD: begin
          if (!rx_mbus_rxreq) begin
            state_q <= DATA;
          end
        end

        // Discarded word: no bytes to send, go straight back for the next.
        ACKX: begin
          if (!rx_mbus_rxreq) begin
            state_q <= (pend_q && !fail_q && !rx_mbus_rxfail) ? WAITW : STATUS;
          end
        end

        STATUS: begin
          if (accept) begin
            state_q <= IDLE;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  // Output decode depends only on registered state, so rx_char_ready has no
  // combinational path to any output.
  always_comb begin
    rx_mbus_rxack  = 1'b0;
    rx_frame_valid = 1'b0;
    rx_char_valid  = 1'b0;
    rx_char_last   = 1'b0;
    rx_char        = 8'h00;
    case (state_q)
      ACK0, ACKD, ACKX: rx_mbus_rxack = 1'b1;
      HDR: begin
        rx_frame_valid = 1'b1;
        rx_char_valid  = 1'b1;
        rx_char        = {7'b0, bcast_q};
      end
      ADDR: begin
        rx_frame_valid = 1'b1;
        rx_char_valid  = 1'b1;
        rx_char        = addr_q[31:24];
      end
      DATA: begin
        rx_frame_valid = 1'b1;
        rx_char_valid  = 1'b1;
        rx_char        = data_q[31:24];
      end
      WAITW: rx_frame_valid = 1'b1;
      STATUS: begin
        rx_frame_valid = 1'b1;
        rx_char_valid  = 1'b1;
        rx_char_last   = 1'b1;
        rx_char        = {6'b0, ovf_q, fail_q};
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mbus_ice_driver_rx.sv
// ---------------------------------------------------------------------------
// tb_mbus_ice_driver_rx
//
// Drives MBUS messages into mbus_ice_driver_rx and collects the byte frame
// it produces. Expected frames are built from the message contents:
// header, four address bytes, four bytes per forwarded word, status.
// A small MAX_WORDS keeps the overflow path cheap to reach.
// ---------------------------------------------------------------------------
module tb_mbus_ice_driver_rx;

  localparam int MAXW   = 4;
  localparam int BUDGET = 2000;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] rx_mbus_rxaddr;
  logic [31:0] rx_mbus_rxdata;
  logic        rx_mbus_rxreq;
  logic        rx_mbus_rxpend;
  logic        rx_mbus_rxbroadcast;
  logic        rx_mbus_rxfail;
  logic        rx_mbus_rxack;
  logic        rx_frame_valid;
  logic [7:0]  rx_char;
  logic        rx_char_valid;
  logic        rx_char_ready;
  logic        rx_char_last;

  mbus_ice_driver_rx #(.MAX_WORDS(MAXW)) dut (
    .clk                 (clk),
    .reset               (reset),
    .rx_mbus_rxaddr      (rx_mbus_rxaddr),
    .rx_mbus_rxdata      (rx_mbus_rxdata),
    .rx_mbus_rxreq       (rx_mbus_rxreq),
    .rx_mbus_rxpend      (rx_mbus_rxpend),
    .rx_mbus_rxbroadcast (rx_mbus_rxbroadcast),
    .rx_mbus_rxfail      (rx_mbus_rxfail),
    .rx_mbus_rxack       (rx_mbus_rxack),
    .rx_frame_valid      (rx_frame_valid),
    .rx_char             (rx_char),
    .rx_char_valid       (rx_char_valid),
    .rx_char_ready       (rx_char_ready),
    .rx_char_last        (rx_char_last)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] msgData[$];
  logic [7:0]  gotBytes[$];
  logic        gotLast[$];
  int          ackRises = 0;
  logic        ackPrev = 1'b0;

  // Count rising edges of rxack so each message's handshake count is known.
  always @(negedge clk) begin
    if (rx_mbus_rxack && !ackPrev) ackRises <= ackRises + 1;
    ackPrev <= rx_mbus_rxack;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic waitAck(input logic level, input string tag);
    int guard = 0;
    while (rx_mbus_rxack !== level && guard < BUDGET) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= BUDGET) checkOutput(tag, 32'(rx_mbus_rxack), 32'(level));
  endtask

  // MBUS side: one 4-phase handshake per word. failAfter>0 pulses rxfail
  // after that many words; coincident raises rxfail together with the
  // second word's rxreq while the block waits for it.
  task automatic driveMbus(input int n, input logic bcast, input logic [31:0] addr,
                           input int failAfter, input bit coincident);
    for (int i = 0; i < n; i++) begin
      waitAck(1'b0, "ackLowTimeout");
      if (coincident && i == 1) begin
        int guard = 0;
        while (!(rx_frame_valid && !rx_char_valid) && guard < BUDGET) begin
          @(negedge clk);
          guard++;
        end
        if (guard >= BUDGET) checkOutput("waitwTimeout", 32'd0, 32'd1);
        rx_mbus_rxdata = msgData[i];
        rx_mbus_rxpend = (i < n - 1);
        rx_mbus_rxreq  = 1'b1;
        rx_mbus_rxfail = 1'b1;
        @(negedge clk);
        rx_mbus_rxreq  = 1'b0;
        rx_mbus_rxfail = 1'b0;
        repeat (3) begin
          @(negedge clk);
          checkOutput("noAckAfterFail", 32'(rx_mbus_rxack), 32'd0);
        end
        return;
      end
      if (i == 0) begin
        rx_mbus_rxaddr      = addr;
        rx_mbus_rxbroadcast = bcast;
      end
      rx_mbus_rxdata = msgData[i];
      rx_mbus_rxpend = (i < n - 1);
      rx_mbus_rxreq  = 1'b1;
      if (i == 0) begin
        @(negedge clk);
        checkOutput("firstAck", 32'(rx_mbus_rxack), 32'd1);
      end
      waitAck(1'b1, "ackHighTimeout");
      if (i > 0)
        checkOutput("ackGate", 32'(gotBytes.size() >= 5 + 4 * ((i < MAXW) ? i : MAXW)), 32'd1);
      rx_mbus_rxreq       = 1'b0;
      rx_mbus_rxpend      = 1'b0;
      rx_mbus_rxdata      = $urandom;
      rx_mbus_rxaddr      = $urandom;
      rx_mbus_rxbroadcast = 1'($urandom_range(0, 1));
      if (failAfter == i + 1) begin
        waitAck(1'b0, "ackLowTimeout");
        repeat ($urandom_range(0, 6)) @(negedge clk);
        rx_mbus_rxfail = 1'b1;
        @(negedge clk);
        rx_mbus_rxfail = 1'b0;
        return;
      end
    end
  endtask

  // Byte side: accept bytes (optionally with random ready) until the last
  // byte, checking that a stalled byte is held unchanged.
  task automatic collectBytes(input bit randReady);
    bit         done = 0;
    bit         hold = 0;
    int         cyc = 0;
    logic [7:0] hChar = 8'h00;
    logic       hLast = 1'b0;
    while (!done && cyc < BUDGET * 4) begin
      @(negedge clk);
      cyc++;
      if (hold) begin
        checkOutput("holdValid", 32'(rx_char_valid), 32'd1);
        checkOutput("holdChar", 32'(rx_char), 32'(hChar));
        checkOutput("holdLast", 32'(rx_char_last), 32'(hLast));
      end
      rx_char_ready = randReady ? 1'($urandom_range(0, 1)) : 1'b1;
      if (rx_char_valid && rx_char_ready) begin
        gotBytes.push_back(rx_char);
        gotLast.push_back(rx_char_last);
        done = rx_char_last;
      end
      hold  = rx_char_valid && !rx_char_ready;
      hChar = rx_char;
      hLast = rx_char_last;
    end
    if (!done) checkOutput("frameTimeout", 32'd0, 32'd1);
  endtask

  // Run one message (words already in msgData) and compare the frame with
  // the one built from the message contents.
  task automatic applyStimulus(input int n, input logic bcast, input logic [31:0] addr,
                               input int failAfter, input bit coincident, input bit randReady);
    int         a0;
    int         sent;
    int         fwd;
    int         m;
    logic [7:0] exp[$];
    logic [31:0] w;
    a0 = ackRises;
    gotBytes.delete();
    gotLast.delete();
    fork
      driveMbus(n, bcast, addr, failAfter, coincident);
      collectBytes(randReady);
    join
    @(negedge clk);
    rx_char_ready = 1'b0;
    checkOutput("frameValidEnd", 32'(rx_frame_valid), 32'd0);
    repeat (2) @(negedge clk);

    sent = (failAfter > 0) ? failAfter : (coincident ? 1 : n);
    fwd  = (sent < MAXW) ? sent : MAXW;
    exp.push_back({7'b0, bcast});
    for (int b = 3; b >= 0; b--) exp.push_back(8'((addr >> (8 * b)) & 32'hFF));
    for (int k = 0; k < fwd; k++) begin
      w = msgData[k];
      for (int b = 3; b >= 0; b--) exp.push_back(8'((w >> (8 * b)) & 32'hFF));
    end
    exp.push_back({6'b0, sent > MAXW, (failAfter > 0) || coincident});

    checkOutput("frameLen", 32'(gotBytes.size()), 32'(exp.size()));
    m = (gotBytes.size() < exp.size()) ? gotBytes.size() : exp.size();
    for (int j = 0; j < m; j++) begin
      checkOutput($sformatf("byte%0d", j), 32'(gotBytes[j]), 32'(exp[j]));
      checkOutput($sformatf("last%0d", j), 32'(gotLast[j]), 32'(j == exp.size() - 1));
    end
    checkOutput("ackCount", 32'(ackRises - a0), 32'(sent));
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_ack"}, 32'(rx_mbus_rxack), 32'd0);
    checkOutput({tag, "_frame"}, 32'(rx_frame_valid), 32'd0);
    checkOutput({tag, "_valid"}, 32'(rx_char_valid), 32'd0);
    checkOutput({tag, "_char"}, 32'(rx_char), 32'd0);
    checkOutput({tag, "_last"}, 32'(rx_char_last), 32'd0);
  endtask

  // Start a message, accept the header, then reset while in the address
  // bytes with rxreq low.
  task automatic resetMidFrame();
    int guard = 0;
    rx_mbus_rxaddr = $urandom;
    rx_mbus_rxdata = $urandom;
    rx_mbus_rxpend = 1'b0;
    rx_mbus_rxreq  = 1'b1;
    waitAck(1'b1, "rstAckTimeout");
    rx_mbus_rxreq = 1'b0;
    while (!rx_char_valid && guard < BUDGET) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= BUDGET) checkOutput("rstHdrTimeout", 32'd0, 32'd1);
    rx_char_ready = 1'b1;
    @(negedge clk);
    rx_char_ready = 1'b0;
    @(negedge clk);
    checkOutput("inAddr", 32'(rx_char_valid && rx_frame_valid), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    checkIdleOutputs("midReset");
    reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int          n;
    int          fa;
    bit          co;
    logic [31:0] ad;
    reset               = 1'b1;
    rx_mbus_rxaddr      = '0;
    rx_mbus_rxdata      = '0;
    rx_mbus_rxreq       = 1'b0;
    rx_mbus_rxpend      = 1'b0;
    rx_mbus_rxbroadcast = 1'b0;
    rx_mbus_rxfail      = 1'b0;
    rx_char_ready       = 1'b0;
    repeat (3) @(negedge clk);
    checkIdleOutputs("reset");
    reset = 1'b0;
    @(negedge clk);

    $display("[TB] single word");
    msgData = '{32'hDEAD_BEEF};
    applyStimulus(1, 1'b0, 32'h0000_00A5, 0, 0, 0);

    $display("[TB] three words broadcast");
    msgData = '{32'h1122_3344, 32'h5566_7788, 32'h99AA_BBCC};
    applyStimulus(3, 1'b1, 32'h1234_5678, 0, 0, 0);
    applyStimulus(3, 1'b1, 32'h1234_5678, 0, 0, 1);

    $display("[TB] fail after first word");
    applyStimulus(3, 1'b0, 32'hCAFE_0001, 1, 0, 0);

    $display("[TB] overflow");
    msgData = '{32'hA0A1_A2A3, 32'hB0B1_B2B3, 32'hC0C1_C2C3, 32'hD0D1_D2D3,
                32'hE0E1_E2E3, 32'hF0F1_F2F3};
    applyStimulus(6, 1'b0, 32'h0F0F_0F0F, 0, 0, 1);

    $display("[TB] fail coincident with request");
    applyStimulus(3, 1'b1, 32'h5A5A_A5A5, 0, 1, 0);

    $display("[TB] reset mid-frame");
    resetMidFrame();
    msgData = '{32'h0BAD_F00D};
    applyStimulus(1, 1'b0, 32'h8000_0001, 0, 0, 0);

    $display("[TB] random messages");
    for (int it = 0; it < 25; it++) begin
      n  = $urandom_range(1, 7);
      ad = $urandom;
      msgData.delete();
      for (int k = 0; k < n; k++) msgData.push_back($urandom);
      fa = (n > 1 && $urandom_range(0, 2) == 0) ? $urandom_range(1, n - 1) : 0;
      co = (fa == 0 && n > 1 && $urandom_range(0, 4) == 0);
      applyStimulus(n, 1'($urandom_range(0, 1)), ad, fa, co, 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
